// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encodings,
// requester IDs and the legal memory latency window.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester IDs double as bit positions in the arbiter request vector
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // lat_cnt is 4 bits wide, so latency is confined to 1..15
  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 15;

  // Forces an out-of-range latency into the range the counter can express
  function automatic int clamp_latency(input int lat);
    if (lat < MEM_LATENCY_MIN) return MEM_LATENCY_MIN;
    if (lat > MEM_LATENCY_MAX) return MEM_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick. Purely combinational; the caller owns the
// last-grant register and decides when to update it.
module rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // A lone requester wins outright; on a tie the one not granted last wins
  always_comb begin
    gnt_valid = |req;
    gnt_id    = OWN_CPU;
    if (req[OWN_CPU] && req[OWN_DMA]) begin
      gnt_id = ~last;
    end else if (req[OWN_DMA]) begin
      gnt_id = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between the CPU and the DMA engine. One access at a
// time: IDLE -> ACCESS (MEM_LATENCY cycles of chip-select) -> RESP (ack).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         LAT_EFF  = clamp_latency(MEM_LATENCY);
  localparam logic [3:0] LAT_LAST = 4'(LAT_EFF - 1);

  state_t              state_reg;
  logic [3:0]          lat_cnt_reg;
  logic                owner_reg;
  logic                last_grant_reg;
  logic                cpu_ack_reg;
  logic                dma_ack_reg;
  logic [DATA_W-1:0]   cpu_rdata_reg;
  logic [DATA_W-1:0]   dma_rdata_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic                mem_cs_reg;
  logic                mem_oe_reg;
  logic                mem_we_reg;

  logic                gnt_valid;
  logic                gnt_id;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;

  rr_arb2 u_rr_arb2 (
    .req       ({dma_req, cpu_req}),
    .last      (last_grant_reg),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Route the winning requester's command bundle toward the latch point
  always_comb begin
    pick_we    = cpu_we;
    pick_addr  = cpu_addr;
    pick_wdata = cpu_wdata;
    if (gnt_id == OWN_DMA) begin
      pick_we    = dma_we;
      pick_addr  = dma_addr;
      pick_wdata = dma_wdata;
    end
  end

  // Access sequencer; every bus strobe and ack is driven straight from here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= '0;
      owner_reg      <= OWN_CPU;
      last_grant_reg <= OWN_DMA;
      cpu_ack_reg    <= 1'b0;
      dma_ack_reg    <= 1'b0;
      cpu_rdata_reg  <= '0;
      dma_rdata_reg  <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_cs_reg     <= 1'b0;
      mem_oe_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
    end else begin
      cpu_ack_reg <= 1'b0;
      dma_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (gnt_valid) begin
            owner_reg      <= gnt_id;
            last_grant_reg <= gnt_id;
            mem_addr_reg   <= pick_addr;
            mem_wdata_reg  <= pick_wdata;
            mem_cs_reg     <= 1'b1;
            mem_oe_reg     <= ~pick_we;
            mem_we_reg     <= pick_we;
            lat_cnt_reg    <= '0;
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt_reg == LAT_LAST) begin
            // mem_we_reg still reflects the access type on this last cycle
            mem_cs_reg <= 1'b0;
            mem_oe_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            state_reg  <= RESP;
            if (owner_reg == OWN_CPU) begin
              cpu_ack_reg <= 1'b1;
              if (!mem_we_reg) cpu_rdata_reg <= mem_rdata;
            end else begin
              dma_ack_reg <= 1'b1;
              if (!mem_we_reg) dma_rdata_reg <= mem_rdata;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_reg;
  assign dma_ack   = dma_ack_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign dma_rdata = dma_rdata_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_cs    = mem_cs_reg;
  assign mem_oe    = mem_oe_reg;
  assign mem_we    = mem_we_reg;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single SM83 memory bus (boot ROM / WRAM behind the address decoder) between two requesters: the CPU core and the OAM/general DMA engine. The block arbitrates with a 2-way round-robin and sequences one access at a time. It drives the decoder's mem_cs/mem_oe plus mem_we, waits a fixed memory latency, and returns read data with a one-cycle ack pulse. It sits between the requesters and address_decode; nothing else drives the memory bus.

Parameters:
MEM_LATENCY, 1, cycles from the first mem_cs cycle until mem_rdata is valid; legal range 1..15.
ADDR_W, 16, address width.
DATA_W, 8, data width.

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1
dma_req / dma_we / dma_addr / dma_wdata  in  1/1/ADDR_W/DATA_W  DMA request bundle, same rules as the CPU bundle
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  DATA_W  read data; valid while dma_ack=1
mem_addr  out  ADDR_W  address to the decoder
mem_wdata  out  DATA_W  write data to memories
mem_cs  out  1  chip-select qualifier to the decoder
mem_oe  out  1  read-enable qualifier to the decoder
mem_we  out  1  write enable
mem_rdata  in  DATA_W  muxed read data from memories

Behaviour:
- All outputs are registered. On reset: every output is 0, state=IDLE, last_grant=DMA, so the CPU wins the first tie.
- States:
  - IDLE: if any request is pending, select a winner and latch its we/addr/wdata plus owner, then go to ACCESS with lat_cnt=0.
  - ACCESS: mem_cs=1. mem_oe=~we and mem_we=we for the full ACCESS duration. mem_addr/mem_wdata hold the latched values. lat_cnt increments each cycle.
  - Leaving ACCESS: when lat_cnt==MEM_LATENCY-1, capture mem_rdata (reads) and go to RESP.
  - RESP: mem_cs/oe/we=0; the owner's ack=1 for exactly this cycle, with the owner's rdata equal to the captured value. Next state is IDLE.
- Arbitration:
  - Only one requester pending: it wins.
  - Both pending: the one that is not last_grant wins.
  - last_grant updates at grant time.
- Latency: a request seen in IDLE at cycle N gets mem_cs during N+1..N+MEM_LATENCY and ack at N+MEM_LATENCY+1. Sustained throughput is one access per MEM_LATENCY+2 cycles.
- Handshake:
  - A requester must not change we/addr/wdata while req=1 and no ack has been received.
  - req still high in the cycle after ack is treated as a new request.
  - The non-owner's ack stays 0.
- req dropped mid-access: the access completes and ack is still pulsed; writes are not cancelled.
- Both requests rising in the same cycle: resolved purely by last_grant; no request is lost, and the loser stays pending until granted.
- rdata outputs hold their last value outside ack; writes leave rdata unchanged.
- mem_addr/mem_wdata hold their last value in IDLE/RESP; they are only meaningful while mem_cs=1.
- Reset mid-access: the next edge forces IDLE with all strobes/acks at 0, and the in-flight transaction is dropped without an ack.
- lat_cnt is 4 bits; MEM_LATENCY=1 makes ACCESS last a single cycle.

Decomposition:
- Shared header mem_bus_defs.vh:
  - state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - owner IDs (OWN_CPU=1'b0, OWN_DMA=1'b1)
  - MEM_LATENCY bounds
- One sub-module, rr_arb2: 2-way round-robin pick.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_id.
  - Combinational; the last_grant register lives in the parent.

Test Plan:
- Single CPU read, MEM_LATENCY=1, cpu_addr=16'h0010, memory returns 8'hA5 -> mem_cs=mem_oe=1 for 1 cycle, cpu_ack at cycle N+2, cpu_rdata=8'hA5, dma_ack stays 0.
- DMA write, MEM_LATENCY=3, dma_addr=16'hC123, dma_wdata=8'h3C -> mem_we=1 and mem_oe=0 for 3 cycles, mem_addr=16'hC123, dma_ack at N+4, dma_rdata unchanged.
- cpu_req and dma_req held high together from reset for 4 transactions -> grant order CPU, DMA, CPU, DMA, each ack spaced MEM_LATENCY+2 cycles.
- CPU drops req in the middle of ACCESS -> the access completes and cpu_ack still pulses once; with no other requester, the block returns to IDLE with mem_cs=0.
- rst asserted during ACCESS of a DMA read -> on the next edge mem_cs/oe/we=0 and both acks=0 with no ack ever issued; after rst, a pending tie grants the CPU first.
- Back-to-back CPU requests with req kept high and new addr after ack (16'hC000 then 16'hC001) -> two distinct accesses with correct addresses and no merged or skipped ack.
